// File: rtl/sys_ctrl.sv
// Command sequencer: parses UART byte frames into register-file writes/reads and
// ALU operations, and streams the response bytes into the TX FIFO.
module sys_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
    input  logic                      RX_D_VLD,
    input  logic                      RX_ERR,
    output logic                      RF_WrEn,
    output logic                      RF_RdEn,
    output logic [ADDR_WIDTH-1:0]     RF_Address,
    output logic [DATA_WIDTH-1:0]     RF_WrData,
    input  logic [DATA_WIDTH-1:0]     RF_RdData,
    input  logic                      RF_RdData_VLD,
    output logic                      ALU_EN,
    output logic [FUN_WIDTH-1:0]      ALU_FUN,
    input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
    input  logic                      ALU_OUT_VLD,
    output logic [DATA_WIDTH-1:0]     TX_P_DATA,
    output logic                      TX_D_VLD,
    input  logic                      FIFO_FULL,
    output logic                      Busy
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] WR_ADDR  = 4'd1;
    localparam logic [3:0] WR_DATA  = 4'd2;
    localparam logic [3:0] RD_ADDR  = 4'd3;
    localparam logic [3:0] RD_WAIT  = 4'd4;
    localparam logic [3:0] OPA      = 4'd5;
    localparam logic [3:0] OPB      = 4'd6;
    localparam logic [3:0] FUN      = 4'd7;
    localparam logic [3:0] ALU_WAIT = 4'd8;
    localparam logic [3:0] TX_LO    = 4'd9;
    localparam logic [3:0] TX_HI    = 4'd10;

    localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);

    // Operands of a CC frame land in these two register-file locations.
    localparam logic [ADDR_WIDTH-1:0] ADDR_OP_A = ADDR_WIDTH'(1'b0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_OP_B = ADDR_WIDTH'(1'b1);

    logic [3:0]              state_r, state_s;
    logic [ADDR_WIDTH-1:0]   addr_hold_r, addr_hold_s;
    logic [2*DATA_WIDTH-1:0] res_r, res_s;
    logic                    single_r, single_s;

    logic                    rx_ok_s, rx_bad_s;
    logic                    wr_en_s, rd_en_s, alu_en_s, tx_vld_s, busy_s;
    logic [ADDR_WIDTH-1:0]   addr_s;
    logic [DATA_WIDTH-1:0]   wr_data_s, tx_data_s;
    logic [FUN_WIDTH-1:0]    fun_s;

    assign rx_ok_s  = RX_D_VLD & ~RX_ERR;
    assign rx_bad_s = RX_D_VLD & RX_ERR;

    // Next-state and next-output decode; strobes default low, data outputs hold.
    always_comb begin
        state_s     = state_r;
        addr_hold_s = addr_hold_r;
        res_s       = res_r;
        single_s    = single_r;
        wr_en_s     = 1'b0;
        rd_en_s     = 1'b0;
        alu_en_s    = 1'b0;
        tx_vld_s    = 1'b0;
        addr_s      = RF_Address;
        wr_data_s   = RF_WrData;
        fun_s       = ALU_FUN;
        tx_data_s   = TX_P_DATA;

        case (state_r)
            IDLE: begin
                if (rx_ok_s) begin
                    case (RX_P_DATA)
                        CMD_WR:      state_s = WR_ADDR;
                        CMD_RD:      state_s = RD_ADDR;
                        CMD_ALU_OP:  state_s = OPA;
                        CMD_ALU_NOP: state_s = FUN;
                        default:     state_s = IDLE;
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            WR_ADDR: begin
                if (rx_bad_s) begin
                    state_s = IDLE;
                end else if (rx_ok_s) begin
                    addr_hold_s = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_s     = WR_DATA;
                end else begin
                    state_s = WR_ADDR;
                end
            end
            WR_DATA: begin
                if (rx_bad_s) begin
                    state_s = IDLE;
                end else if (rx_ok_s) begin
                    wr_en_s   = 1'b1;
                    addr_s    = addr_hold_r;
                    wr_data_s = RX_P_DATA;
                    state_s   = IDLE;
                end else begin
                    state_s = WR_DATA;
                end
            end
            RD_ADDR: begin
                if (rx_bad_s) begin
                    state_s = IDLE;
                end else if (rx_ok_s) begin
                    rd_en_s = 1'b1;
                    addr_s  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_s = RD_WAIT;
                end else begin
                    state_s = RD_ADDR;
                end
            end
            RD_WAIT: begin
                // A read answers with one byte only, so TX_HI is skipped.
                if (RF_RdData_VLD) begin
                    res_s    = {{DATA_WIDTH{1'b0}}, RF_RdData};
                    single_s = 1'b1;
                    state_s  = TX_LO;
                end else begin
                    state_s = RD_WAIT;
                end
            end
            OPA: begin
                if (rx_bad_s) begin
                    state_s = IDLE;
                end else if (rx_ok_s) begin
                    wr_en_s   = 1'b1;
                    addr_s    = ADDR_OP_A;
                    wr_data_s = RX_P_DATA;
                    state_s   = OPB;
                end else begin
                    state_s = OPA;
                end
            end
            OPB: begin
                if (rx_bad_s) begin
                    state_s = IDLE;
                end else if (rx_ok_s) begin
                    wr_en_s   = 1'b1;
                    addr_s    = ADDR_OP_B;
                    wr_data_s = RX_P_DATA;
                    state_s   = FUN;
                end else begin
                    state_s = OPB;
                end
            end
            FUN: begin
                if (rx_bad_s) begin
                    state_s = IDLE;
                end else if (rx_ok_s) begin
                    alu_en_s = 1'b1;
                    fun_s    = RX_P_DATA[FUN_WIDTH-1:0];
                    state_s  = ALU_WAIT;
                end else begin
                    state_s = FUN;
                end
            end
            ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    res_s    = ALU_OUT;
                    single_s = 1'b0;
                    state_s  = TX_LO;
                end else begin
                    state_s = ALU_WAIT;
                end
            end
            TX_LO: begin
                if (!FIFO_FULL) begin
                    tx_vld_s  = 1'b1;
                    tx_data_s = res_r[DATA_WIDTH-1:0];
                    state_s   = single_r ? IDLE : TX_HI;
                end else begin
                    state_s = TX_LO;
                end
            end
            TX_HI: begin
                if (!FIFO_FULL) begin
                    tx_vld_s  = 1'b1;
                    tx_data_s = res_r[2*DATA_WIDTH-1:DATA_WIDTH];
                    state_s   = IDLE;
                end else begin
                    state_s = TX_HI;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= IDLE;
            addr_hold_r <= {ADDR_WIDTH{1'b0}};
            res_r       <= {(2*DATA_WIDTH){1'b0}};
            single_r    <= 1'b0;
            RF_WrEn     <= 1'b0;
            RF_RdEn     <= 1'b0;
            RF_Address  <= {ADDR_WIDTH{1'b0}};
            RF_WrData   <= {DATA_WIDTH{1'b0}};
            ALU_EN      <= 1'b0;
            ALU_FUN     <= {FUN_WIDTH{1'b0}};
            TX_P_DATA   <= {DATA_WIDTH{1'b0}};
            TX_D_VLD    <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            state_r     <= state_s;
            addr_hold_r <= addr_hold_s;
            res_r       <= res_s;
            single_r    <= single_s;
            RF_WrEn     <= wr_en_s;
            RF_RdEn     <= rd_en_s;
            RF_Address  <= addr_s;
            RF_WrData   <= wr_data_s;
            ALU_EN      <= alu_en_s;
            ALU_FUN     <= fun_s;
            TX_P_DATA   <= tx_data_s;
            TX_D_VLD    <= tx_vld_s;
            Busy        <= busy_s;
        end
    end

endmodule

// File: doc/sys_ctrl.md
Name: sys_ctrl

Overview:
Command sequencer between the UART receive/transmit datapath and the system register file and ALU. Parses byte frames delivered by the UART receiver and issues register-file writes and reads, or ALU operations. Pushes response bytes into the TX FIFO that feeds the UART transmitter. Single clock domain: the receiver's parallel output is already synchronised into this domain.

Parameters:
DATA_WIDTH, 8, width of UART bytes, RF data and ALU operands
ADDR_WIDTH, 4, register-file address width
FUN_WIDTH, 4, ALU function code width

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
RX_P_DATA  in  DATA_WIDTH  received byte
RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
RX_ERR  in  1  parity or framing error on the byte qualified by RX_D_VLD
RF_WrEn  out  1  register-file write strobe
RF_RdEn  out  1  register-file read strobe
RF_Address  out  ADDR_WIDTH  register-file address
RF_WrData  out  DATA_WIDTH  register-file write data
RF_RdData  in  DATA_WIDTH  register-file read data
RF_RdData_VLD  in  1  read data valid, 1+ cycles after RF_RdEn
ALU_EN  out  1  ALU operation strobe
ALU_FUN  out  FUN_WIDTH  ALU function code
ALU_OUT  in  2*DATA_WIDTH  ALU result
ALU_OUT_VLD  in  1  ALU result valid
TX_P_DATA  out  DATA_WIDTH  byte to TX FIFO
TX_D_VLD  out  1  TX FIFO write strobe
FIFO_FULL  in  1  TX FIFO full
Busy  out  1  high whenever state is not IDLE

Behaviour:
- All outputs registered. On RST: every output is 0 and state is IDLE. Reset mid-frame discards the partial frame; no strobe is emitted after reset.
- A byte is accepted only when RX_D_VLD=1. Any RX_D_VLD with RX_ERR=1 aborts the current frame: return to IDLE with no RF/ALU/TX strobe.
- Command bytes are decoded in IDLE only:
  - 0xAA: RF write, frame AA, addr, data.
  - 0xBB: RF read, frame BB, addr.
  - 0xCC: ALU with operands, frame CC, A, B, fun.
  - 0xDD: ALU without operands, frame DD, fun.
  - Any other byte in IDLE is ignored; stay in IDLE.
- Address bytes use the low ADDR_WIDTH bits. Function bytes use the low FUN_WIDTH bits. Upper bits are ignored.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, TX_LO, TX_HI.
- RF write: byte accepted in WR_DATA, then the next cycle RF_WrEn=1 for exactly one cycle with RF_Address/RF_WrData valid, then IDLE.
- RF read: byte accepted in RD_ADDR, then the next cycle RF_RdEn=1 for one cycle, then RD_WAIT. On RF_RdData_VLD, capture RF_RdData and go to TX_LO (single-byte response, skip TX_HI).
- ALU CC:
  - Operand A accepted in OPA: one-cycle RF_WrEn to address 0.
  - Operand B accepted in OPB: one-cycle RF_WrEn to address 1.
  - Fun accepted in FUN: the next cycle ALU_EN=1 for one cycle with ALU_FUN, then ALU_WAIT.
- ALU DD: goes straight to FUN; ALU uses the existing RF[0]/RF[1].
- ALU_WAIT: on ALU_OUT_VLD, capture ALU_OUT and go to TX_LO, then TX_HI (low byte first).
- TX_LO/TX_HI: if FIFO_FULL=0, TX_D_VLD=1 for one cycle with the byte, then advance. If FIFO_FULL=1, hold the state with TX_D_VLD=0 indefinitely. No byte is ever dropped or duplicated.
- RX_D_VLD arriving in RD_WAIT, ALU_WAIT, TX_LO or TX_HI is ignored, unless RX_ERR=1, which is also ignored there (the operation completes).
- No timeout: the wait states hold until their valid input arrives.
- Busy=0 only in IDLE. Next command byte is accepted the cycle after returning to IDLE.

Test Plan:
- Bytes AA,05,3C with 4-cycle gaps -> one RF_WrEn pulse, Address=5, WrData=0x3C; no TX_D_VLD; Busy back to 0.
- BB,07; RF returns 0x5A three cycles after RF_RdEn -> RF_RdEn pulse with Address=7, then exactly one TX_D_VLD with 0x5A.
- CC,12,34,00; ALU_OUT=0x0046 -> RF writes addr0=0x12 then addr1=0x34, ALU_EN with FUN=0, then TX bytes 0x46 then 0x00.
- DD,02 with FIFO_FULL=1 for 10 cycles after ALU_OUT_VLD (ALU_OUT=0x1234) -> no TX_D_VLD while full, then 0x34 then 0x12, each exactly once.
- AA,05 followed by a data byte with RX_ERR=1 -> no RF_WrEn, IDLE; then a garbage byte 0x11 -> ignored, Busy stays 0.
- RST asserted in RD_WAIT, RF_RdData_VLD then pulses -> all outputs 0, no TX_D_VLD, IDLE after reset release.
